// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle arithmetic/logic ops plus iterative
// shift-add multiply and restoring unsigned divide, result and flags registered.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ZF,
  output logic             CF,
  output logic             OF,
  output logic             SF,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_INC   = 4'b1010;
  localparam logic [3:0] OP_DEC   = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nx;
  logic                 accept, is_multi, last, ld;
  logic [3:0]           op_p0;
  logic [WIDTH-1:0]     b_p0;
  logic [2*WIDTH-1:0]   acc_p0, acc_nx;
  logic [SW-1:0]        cnt;
  logic [WIDTH+1:0]     fast;
  logic [WIDTH:0]       hi_sum, rem_sh;
  logic                 rem_ge;
  logic [WIDTH-1:0]     ld_res;
  logic                 ld_cf, ld_of;

  // Returns {cf, of, result} for every op that completes in one cycle.
  function automatic logic [WIDTH+1:0] alu_fast(input logic [3:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs, ys;
    logic [WIDTH-1:0]        y2, res;
    logic [WIDTH:0]          sum;
    logic [SW-1:0]           sh;
    logic                    sub, cf, of;
    xs  = x;
    ys  = y;
    sh  = y[SW-1:0];
    y2  = (f == OP_INC || f == OP_DEC) ? WIDTH'(1) : y;
    sub = (f == OP_SUB || f == OP_DEC);
    sum = sub ? ({1'b0, x} - {1'b0, y2}) : ({1'b0, x} + {1'b0, y2});
    res = '0;
    cf  = 1'b0;
    of  = 1'b0;
    case (f)
      OP_ADD, OP_INC: begin
        res = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        of  = (x[WIDTH-1] == y2[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        res = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        of  = (x[WIDTH-1] != y2[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLL:  res = x << sh;
      OP_SRL:  res = x >> sh;
      OP_SRA:  res = xs >>> sh;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, (xs < ys)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_XOR:  res = x ^ y;
      OP_OR:   res = x | y;
      OP_AND:  res = x & y;
      default: res = '0;
    endcase
    return {cf, of, res};
  endfunction

  assign in_ready  = rst_n && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign is_multi  = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign last      = (state == CALC) && (cnt == SW'(WIDTH-1));
  assign ld        = (accept && !is_multi) || last;

  // One multiply or divide step; acc holds {hi, lo} of product or {rem, quotient}
  always_comb begin
    acc_nx = acc_p0;
    hi_sum = '0;
    rem_sh = '0;
    rem_ge = 1'b0;
    if (op_p0 == OP_MUL || op_p0 == OP_MULHU) begin
      hi_sum = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + (acc_p0[0] ? {1'b0, b_p0} : '0);
      acc_nx = {hi_sum, acc_p0[WIDTH-1:1]};
    end else begin
      rem_sh = acc_p0[2*WIDTH-1:WIDTH-1];
      rem_ge = (rem_sh >= {1'b0, b_p0});
      acc_nx = {rem_sh[WIDTH-1:0] - (rem_ge ? b_p0 : '0), acc_p0[WIDTH-2:0], rem_ge};
    end
  end

  always_comb begin
    fast   = alu_fast(op, a, b);
    ld_res = fast[WIDTH-1:0];
    ld_of  = fast[WIDTH];
    ld_cf  = fast[WIDTH+1];
    if (state == CALC) begin
      ld_cf = 1'b0;
      ld_of = 1'b0;
      case (op_p0)
        OP_MUL:   begin ld_res = acc_nx[WIDTH-1:0];       ld_cf = |acc_nx[2*WIDTH-1:WIDTH]; ld_of = ld_cf; end
        OP_MULHU: begin ld_res = acc_nx[2*WIDTH-1:WIDTH]; ld_cf = |acc_nx[2*WIDTH-1:WIDTH]; ld_of = ld_cf; end
        OP_DIVU:  ld_res = acc_nx[WIDTH-1:0];
        default:  ld_res = acc_nx[2*WIDTH-1:WIDTH];
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = is_multi ? CALC : DONE;
      CALC:    if (last) state_nx = DONE;
      DONE: begin
        if (accept)         state_nx = is_multi ? CALC : DONE;
        else if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: operand capture and iteration; result/flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
      ZF    <= 1'b0;
      CF    <= 1'b0;
      OF    <= 1'b0;
      SF    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_p0  <= op;
        b_p0   <= b;
        acc_p0 <= {{WIDTH{1'b0}}, a};
        cnt    <= '0;
      end else if (state == CALC) begin
        acc_p0 <= acc_nx;
        cnt    <= cnt + 1'b1;
      end
      if (ld) begin
        out <= ld_res;
        ZF  <= (ld_res == '0);
        SF  <= ld_res[WIDTH-1];
        CF  <= ld_cf;
        OF  <= ld_of;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    op = '0;
  logic          in_ready, out_valid, ZF, CF, OF, SF, busy;
  logic [W-1:0]  out;

  int n_chk = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ZF(ZF), .CF(CF), .OF(OF), .SF(SF), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit multi(input logic [3:0] o);
    return (o == 4'b1100) || (o == 4'b1001) || (o == 4'b1110) || (o == 4'b1111);
  endfunction

  // Returns {result, ZF, CF, OF, SF}
  function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, sr;
    logic [63:0] p;
    logic [31:0] r;
    logic        cf, of;
    int          sh;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    sh = int'(y % 32);
    p  = {32'b0, x} * {32'b0, y};
    cf = 1'b0;
    of = 1'b0;
    r  = '0;
    case (o)
      4'b0000: begin r = x + y; cf = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF; sr = sa + sb; end
      4'b1010: begin r = x + 1; cf = (x == 32'hFFFF_FFFF); sr = sa + 1; end
      4'b1000: begin r = x - y; cf = (x < y); sr = sa - sb; end
      4'b1011: begin r = x - 1; cf = (x == 0); sr = sa - 1; end
      default: sr = 0;
    endcase
    if (o == 4'b0000 || o == 4'b1010 || o == 4'b1000 || o == 4'b1011)
      of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    case (o)
      4'b0001: r = x << sh;
      4'b0101: r = x >> sh;
      4'b1101: r = 32'(sa >>> sh);
      4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0011: r = (x < y) ? 32'd1 : 32'd0;
      4'b0100: r = x ^ y;
      4'b0110: r = x | y;
      4'b0111: r = x & y;
      4'b1100: begin r = p[31:0];  cf = (p[63:32] != 0); of = cf; end
      4'b1001: begin r = p[63:32]; cf = (p[63:32] != 0); of = cf; end
      4'b1110: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'b1111: r = (y == 0) ? x : x % y;
      default: ;
    endcase
    return {r, (r == 0), cf, of, r[31]};
  endfunction

  // Entered and left at #1 after a rising edge with the block idle
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [35:0] e;
    int lat, bc, bad_rdy;
    e = model(o, x, y);
    chk($sformatf("in_ready idle op%b", o), in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
    lat = 1; bc = 0; bad_rdy = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      if (busy && in_ready) bad_rdy++;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency op%b", o), lat, multi(o) ? 33 : 1);
    chk($sformatf("busy cycles op%b", o), bc, multi(o) ? 32 : 0);
    chk($sformatf("in_ready in calc op%b", o), bad_rdy, 0);
    chk($sformatf("out op%b %h,%h", o, x, y), out, e[35:4]);
    chk($sformatf("flags op%b %h,%h", o, x, y), {ZF, CF, OF, SF}, e[3:0]);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain", out_valid, 0);
  endtask

  logic [31:0] ha [4];
  logic [31:0] hb [4];
  logic [31:0] held;
  logic [3:0]  hflags;
  logic [35:0] e;
  int          spurious;

  initial begin
    // reset at start
    repeat (2) @(posedge clk);
    #1;
    chk("reset out", out, 0);
    chk("reset flags", {ZF, CF, OF, SF}, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after release", in_ready, 1);

    // directed corners
    run_op(4'b0000, 32'hFFFF_FFFF, 32'h1);
    run_op(4'b0000, 32'h7FFF_FFFF, 32'h1);
    run_op(4'b1000, 32'd3, 32'd5);
    run_op(4'b1101, 32'h8000_0000, 32'd36);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1);
    run_op(4'b0011, 32'hFFFF_FFFF, 32'd1);
    run_op(4'b1100, 32'h0001_0000, 32'h0001_0000);
    run_op(4'b1001, 32'h0001_0000, 32'h0001_0000);
    run_op(4'b1110, 32'd100, 32'd7);
    run_op(4'b1111, 32'd100, 32'd7);
    run_op(4'b1110, 32'd7, 32'd0);
    run_op(4'b1111, 32'd7, 32'd0);
    run_op(4'b1010, 32'h7FFF_FFFF, 32'd0);
    run_op(4'b1011, 32'h0, 32'd0);
    run_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  o;
      logic [31:0] x, y;
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 20));
        2: x = 32'hFFFF_FFFF;
        3: x = 32'h8000_0000;
        default: ;
      endcase
      run_op(o, x, y);
    end

    // backpressure hold then back-to-back ADDs
    op = 4'b0000; a = 32'd5; b = 32'hFFFF_FFFB; in_valid = 1'b1;
    @(posedge clk); #1;
    held = out; hflags = {ZF, CF, OF, SF};
    chk("hold first result", out, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ha[i] = $urandom;
      hb[i] = $urandom;
    end
    a = ha[0]; b = hb[0];
    for (int i = 0; i < 5; i++) begin
      chk("hold out_valid", out_valid, 1);
      chk("hold in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("hold out", out, held);
      chk("hold flags", {ZF, CF, OF, SF}, hflags);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = ha[i]; b = hb[i];
      @(posedge clk); #1;
      e = model(4'b0000, ha[i], hb[i]);
      chk($sformatf("b2b valid %0d", i), out_valid, 1);
      chk($sformatf("b2b out %0d", i), out, e[35:4]);
      chk($sformatf("b2b flags %0d", i), {ZF, CF, OF, SF}, e[3:0]);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b drained", out_valid, 0);
    out_ready = 1'b0;

    // reset in the middle of a multiply
    run_op(4'b0110, 32'h00F0_0000, 32'h0000_000F);
    op = 4'b1100; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("busy before reset", busy, 1);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("mid reset out", out, 0);
      chk("mid reset flags", {ZF, CF, OF, SF}, 0);
      chk("mid reset out_valid", out_valid, 0);
      chk("mid reset busy", busy, 0);
      chk("mid reset in_ready", in_ready, 0);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after mid reset", in_ready, 1);
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy) spurious++;
      @(posedge clk); #1;
    end
    chk("no result after reset", spurious, 0);
    out_ready = 1'b0;
    run_op(4'b1110, 32'd100, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational ALU. It keeps the existing 4-bit op encoding and ZF/CF/OF/SF flag outputs, generalises the datapath to WIDTH bits and adds iterative multiply and unsigned divide/remainder. Results and flags are registered behind a valid/ready pair. It sits in the execute stage between operand read and writeback, and stalls upstream while a multi-cycle op is in flight.

## Interface
- WIDTH, 32, datapath width; power of two, at least 8; SW = log2(WIDTH).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b; shifts use b[SW-1:0] only.
- op  in  4  operation select.
- out_valid  out  1  out and flags hold a valid result.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- out  out  WIDTH  registered result.
- ZF, CF, OF, SF  out  1 each  registered flags belonging to out.
- busy  out  1  high in CALC.

## Operation
- Op codes:
  - 0000 ADD, 1000 SUB, 1010 INC (a+1), 1011 DEC (a-1).
  - 0001 SLL, 0101 SRL, 1101 SRA (true arithmetic shift; sign-fills).
  - 0010 SLT (signed), 0011 SLTU; result is 0 or 1, zero-extended.
  - 0100 XOR, 0110 OR, 0111 AND.
  - 1100 MUL (low WIDTH bits of the product), 1001 MULHU (high WIDTH bits, unsigned).
  - 1110 DIVU (quotient), 1111 REMU (remainder).
- Flags are computed from the final result, never from the previous out.
  - ZF = (out == 0); SF = out[WIDTH-1].
  - ADD/INC: CF = carry out of bit WIDTH-1.
  - SUB/DEC: CF = borrow, i.e. a < subtrahend unsigned.
  - OF = signed two's-complement overflow for ADD/SUB/INC/DEC.
  - MUL/MULHU: CF = OF = (high half of the product != 0).
  - All other ops: CF = OF = 0.
- MUL/MULHU: shift-add over a 2*WIDTH product register, one bit per cycle, WIDTH iterations.
- DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH iterations.
  - Divide by zero: quotient = all ones, remainder = a. These values fall out naturally from the restoring algorithm.
  - No exception is raised and latency is unchanged.
- FSM:
  - IDLE: on accept of a single-cycle op, go to DONE. On accept of MUL/MULHU/DIVU/REMU, go to CALC with iteration count = 0.
  - CALC: one iteration per cycle. After iteration WIDTH-1, load out and flags and go to DONE.
  - DONE: out_valid = 1. On out_ready, either go to IDLE, or accept a new op in the same cycle and follow the IDLE rules for it.
- in_ready = rst_n && (state == IDLE || (state == DONE && out_ready)). in_ready is never high in CALC.
- Operands and op are captured at accept. Input changes after accept have no effect.

## Timing
- Reset (rst_n low at an edge):
  - State goes to IDLE; out = 0; ZF = CF = OF = SF = 0; out_valid = 0; busy = 0.
  - Any in-flight op is discarded, including mid-CALC; no result is produced.
  - in_ready is 0 while rst_n is low.
- Single-cycle ops: accept at edge N, out_valid = 1 after edge N+1.
- Multi-cycle ops: accept at edge N, busy high after edges N+1 .. N+WIDTH, out_valid after edge N+WIDTH+1. Latency is WIDTH+1 cycles (33 at WIDTH = 32).
- Throughput for single-cycle ops is one per cycle while out_ready is held high.
- Hold: while out_valid && !out_ready, out and flags are stable and no new op is accepted.
- out and flags change only when a new result is loaded or on reset.

## Test plan
- Reset: hold rst_n low for 2 cycles mid-stream -> out = 0, all flags 0, out_valid = 0, in_ready = 0. One cycle after release, in_ready = 1.
- ADD corners:
  - 0xFFFFFFFF + 1 -> out = 0, ZF = 1, CF = 1, OF = 0, SF = 0.
  - 0x7FFFFFFF + 1 -> out = 0x80000000, OF = 1, SF = 1, CF = 0.
  - Both results have out_valid exactly 1 cycle after accept.
- SUB and shifts:
  - SUB 3 - 5 -> 0xFFFFFFFE, CF = 1, SF = 1, OF = 0.
  - SRA 0x80000000 by b = 36 -> 0xF8000000 (shift amount 4).
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU with the same operands -> 0.
- Multiply:
  - MUL 0x00010000 * 0x00010000 -> out = 0, ZF = 1, CF = OF = 1, out_valid 33 cycles after accept, busy high for 32 cycles.
  - MULHU with the same operands -> 1.
- Divide:
  - DIVU 100 / 7 -> 14; REMU -> 2.
  - DIVU 7 / 0 -> 0xFFFFFFFF; REMU 7 / 0 -> 7.
  - All four take 33 cycles.
- Handshake:
  - Hold out_ready = 0 for 5 cycles -> out and flags stable, in_ready = 0 throughout.
  - Then 4 back-to-back ADDs with out_ready = 1 -> 4 results in 4 consecutive cycles.
  - Assert rst_n = 0 at CALC iteration 10 of a MUL -> out_valid stays 0 and no result appears.
